// File: rtl/my_seq_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// rippling the carry through a register; start/busy/done handshake with atomic S/Co/Ov update.
module my_seq_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ov
);

    localparam int unsigned NCH  = WIDTH / CHUNK;
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [31:0]      off;
    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic [CHUNK:0]   sum_c;
    logic             msb_cin;
    logic [WIDTH-1:0] res_upd;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        s_d     = s_q;
        co_d    = co_q;
        ov_d    = ov_q;

        off     = 32'(idx_q) * CHUNK;
        chunk_a = CHUNK'(a_q >> off);
        chunk_b = CHUNK'(b_q >> off);
        sum_c   = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of this chunk, recovered from the sum bit.
        msb_cin = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ sum_c[CHUNK-1];
        // res_q is cleared on capture, so each chunk can simply be OR-ed into place.
        res_upd = res_q | (WIDTH'(sum_c[CHUNK-1:0]) << off);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = Sub ? ~B : B;
                    carry_d = Sub ? ~Ci : Ci;
                    res_d   = '0;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_d   = res_upd;
                carry_d = sum_c[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    s_d     = res_upd;
                    co_d    = sum_c[CHUNK];
                    ov_d    = msb_cin ^ sum_c[CHUNK];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ov_q    <= ov_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign S    = s_q;
    assign Co   = co_q;
    assign Ov   = ov_q;

endmodule

// File: doc/my_seq_adder.md
Name: my_seq_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, rippling carry between chunks through a carry register.
- Successor to the 4-bit combinational ripple adder; generalised in width and chunk size.
- Adds subtract mode, carry-in, signed overflow and a start/busy/done handshake.
- Sits beside the ALU datapath wherever area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits added per clock. CHUNK=WIDTH gives a single-cycle-per-op variant.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE or DONE
A  input  WIDTH  operand A, captured on accepted start
B  input  WIDTH  operand B, captured on accepted start
Ci  input  1  carry-in (Sub=0) or borrow-in (Sub=1), captured on accepted start
Sub  input  1  0: S=A+B+Ci; 1: S=A-B-Ci; captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, high in DONE
S  output  WIDTH  result register
Co  output  1  raw carry-out of MSB; in Sub mode 1 = no borrow
Ov  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, busy=0, done=0, S=0, Co=0, Ov=0, chunk index=0, internal regs cleared. Reset overrides everything, including mid-RUN; the partial result is discarded.
- NCH = WIDTH/CHUNK.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> capture operands -> RUN, index=0.
  - RUN: stays for exactly NCH cycles, then -> DONE.
  - DONE: lasts one cycle. If start=1 -> capture -> RUN (back-to-back); else -> IDLE.
- Capture on accepted start:
  - Areg=A.
  - Breg = Sub ? ~B : B.
  - carry = Sub ? ~Ci : Ci.
  - Sub latched for the operation.
- RUN cycle with index i:
  - Add chunk i (bits i*CHUNK .. i*CHUNK+CHUNK-1, LSB chunk first) of Areg and Breg with the carry register.
  - Store the CHUNK-bit partial sum into an internal result register.
  - Update carry; index++.
  - On the last chunk, also record the carry into the MSB (needed for Ov).
- Transition into DONE updates S, Co and Ov atomically:
  - S = full internal result.
  - Co = final carry.
  - Ov = carry into MSB XOR carry out of MSB.
- S/Co/Ov hold their value until the next transition into DONE. Intermediate chunks are never visible on S.
- Latency: start sampled at edge k -> busy high for edges k+1..k+NCH -> done high in the cycle after edge k+NCH+1. Result is valid when done=1. Throughput is one op per NCH+1 cycles.
- start while in RUN: ignored. Operands are not re-captured; the operation is not restarted.
- Operands and Sub may change freely after capture without affecting the result.
- All arithmetic is modulo 2^WIDTH. Ci and Sub apply only to chunk 0.

Test Plan:
1. WIDTH=16, CHUNK=4: A=0xFFFF, B=0x0001, Ci=0, Sub=0, pulse start -> busy for 4 cycles; done 5 cycles after start; S=0x0000, Co=1, Ov=0.
2. A=0x7FFF, B=0x0001, Ci=0, Sub=0 -> S=0x8000, Co=0, Ov=1. Then A=0x1234, B=0x4321, Ci=1 -> S=0x5556, Co=0, Ov=0.
3. Sub=1: A=0x0005, B=0x0007, Ci=0 -> S=0xFFFE, Co=0, Ov=0. A=0x8000, B=0x0001, Ci=0 -> S=0x7FFF, Co=1, Ov=1. A=0x0010, B=0x0001, Ci=1 -> S=0x000E, Co=1.
4. Start re-pulsed with different A/B during RUN -> ignored; result matches the first operands; done still 5 cycles after the first start. Start held high in the DONE cycle -> second op accepted, busy reasserts next cycle.
5. Assert rst for 1 cycle at the 2nd RUN cycle -> next cycle busy=0, done=0, S=0, Co=0, Ov=0, state IDLE. A following start completes normally with the correct result.
6. Re-run scenarios 1-3 with CHUNK=16 (1 RUN cycle, done 2 cycles after start) and CHUNK=1 (16 RUN cycles) -> identical S/Co/Ov.
